// File: rtl/asi_pkg.sv
// ---------------------------------------------------------------------------
// asi_pkg
//   Shared definitions for the ASI master-side Manchester path. Both
//   man_encoding and man_decoding use this package.
//   Contents:
//     - frame geometry: ASI_NUM_BITS, ASI_HALF_BIT_CLKS
//     - fixed start/end bit values (ASI_ST, ASI_EB)
//     - bit positions of each field in the 14-bit master request
//     - transmitter state encoding
//     - even-parity and frame-builder helper functions
// ---------------------------------------------------------------------------
package asi_pkg;

    localparam int ASI_NUM_BITS      = 14;
    localparam int ASI_HALF_BIT_CLKS = 36;

    localparam logic ASI_ST = 1'b0;
    localparam logic ASI_EB = 1'b1;

    // Field positions; frame[13] is sent first on the line.
    localparam int POS_ST    = 13;
    localparam int POS_CB    = 12;
    localparam int POS_A_LSB = 7;
    localparam int POS_I_LSB = 2;
    localparam int POS_PB    = 1;
    localparam int POS_EB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

    // Even parity over CB, A4..A0 and I4..I0.
    function automatic logic asi_parity(input logic cb,
                                        input logic [4:0] addr,
                                        input logic [4:0] info);
        return cb ^ (^addr) ^ (^info);
    endfunction

    function automatic logic [ASI_NUM_BITS-1:0] asi_build_frame(input logic cb,
                                                                input logic [4:0] addr,
                                                                input logic [4:0] info);
        logic [ASI_NUM_BITS-1:0] f;
        f                   = '0;
        f[POS_ST]           = ASI_ST;
        f[POS_CB]           = cb;
        f[POS_A_LSB +: 5]   = addr;
        f[POS_I_LSB +: 5]   = info;
        f[POS_PB]           = asi_parity(cb, addr, info);
        f[POS_EB]           = ASI_EB;
        return f;
    endfunction

endpackage

// File: rtl/man_encoding_tick_gen.sv
// ---------------------------------------------------------------------------
// man_tick_gen
//   Half-bit timebase. Counts 0..MAX_CNT-1 while enabled and emits a
//   single-cycle terminal pulse on the last count, then wraps to 0.
//   Ports:
//     clk_in  system clock
//     rst     asynchronous active-high reset
//     clr     synchronous clear (wins over en)
//     en      count enable
//     tick    terminal-count pulse (combinational from count and en)
// ---------------------------------------------------------------------------
module man_tick_gen #(
    parameter int MAX_CNT = 36
) (
    input  logic clk_in,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W    = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/man_encoding.sv
// ---------------------------------------------------------------------------
// man_encoding
//   ASI master-request Manchester transmitter. On start (sampled in IDLE)
//   the 14-bit frame ST,CB,A4..A0,I4..I0,PB,EB is latched and sent MSB
//   first, each bit as two halves (~b then b), each half HALF_BIT_CLKS
//   clocks long. A GAP_CLKS idle gap follows, ending in a one-cycle done.
//   Ports:
//     clk_in      system clock
//     rst         asynchronous active-high reset
//     start       frame request (ignored unless idle)
//     cb          control bit
//     addr[4:0]   slave address
//     info[4:0]   information bits
//     manchester  registered serial line
//     tx_en       registered line-driver enable
//     busy        high whenever not idle
//     done        registered one-cycle pulse at end of gap
//     frame       latched frame for readback
// ---------------------------------------------------------------------------
module man_encoding
    import asi_pkg::*;
#(
    parameter int   HALF_BIT_CLKS = ASI_HALF_BIT_CLKS,
    parameter int   NUM_BITS      = ASI_NUM_BITS,
    parameter int   GAP_CLKS      = 216,
    parameter logic IDLE_LEVEL    = 1'b0
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                start,
    input  logic                cb,
    input  logic [4:0]          addr,
    input  logic [4:0]          info,
    output logic                manchester,
    output logic                tx_en,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] frame
);

    localparam int                HIDX_W    = $clog2(2 * NUM_BITS);
    localparam logic [HIDX_W-1:0] HALF_LAST = HIDX_W'(2 * NUM_BITS - 1);
    localparam int                GAP_W     = $clog2(GAP_CLKS);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CLKS - 1);

    tx_state_e             state_q, state_d;
    logic [NUM_BITS-1:0]   frame_q, frame_d;
    logic [NUM_BITS-1:0]   shift_q, shift_d;
    logic [HIDX_W-1:0]     half_idx_q, half_idx_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic                  man_q, man_d;
    logic                  tx_en_q, tx_en_d;
    logic                  done_q, done_d;

    logic [NUM_BITS-1:0]   new_frame;
    logic                  half_tick;

    assign new_frame = asi_build_frame(cb, addr, info);

    man_tick_gen #(
        .MAX_CNT (HALF_BIT_CLKS)
    ) u_tick (
        .clk_in (clk_in),
        .rst    (rst),
        .clr    (state_q != ST_SEND),
        .en     (state_q == ST_SEND),
        .tick   (half_tick)
    );

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        shift_d    = shift_q;
        half_idx_d = half_idx_q;
        gap_cnt_d  = gap_cnt_q;
        man_d      = IDLE_LEVEL;
        tx_en_d    = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    frame_d    = new_frame;
                    shift_d    = new_frame;
                    half_idx_d = '0;
                    state_d    = ST_SEND;
                    man_d      = ~new_frame[NUM_BITS-1];
                    tx_en_d    = 1'b1;
                end
            end
            ST_SEND: begin
                man_d   = man_q;
                tx_en_d = 1'b1;
                if (half_tick) begin
                    if (half_idx_q == HALF_LAST) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                        man_d     = IDLE_LEVEL;
                        tx_en_d   = 1'b0;
                    end else begin
                        half_idx_d = half_idx_q + HIDX_W'(1);
                        if (!half_idx_q[0]) begin
                            // Entering the second half: the true bit value.
                            man_d = shift_q[NUM_BITS-1];
                        end else begin
                            // Bit finished: move to the next bit's inverted first half.
                            shift_d = shift_q << 1;
                            man_d   = ~shift_q[NUM_BITS-2];
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            shift_q    <= '0;
            half_idx_q <= '0;
            gap_cnt_q  <= '0;
            man_q      <= IDLE_LEVEL;
            tx_en_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            shift_q    <= shift_d;
            half_idx_q <= half_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            man_q      <= man_d;
            tx_en_q    <= tx_en_d;
            done_q     <= done_d;
        end
    end

    assign manchester = man_q;
    assign tx_en      = tx_en_q;
    assign done       = done_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame      = frame_q;

endmodule
